// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: stand-in for the external RTC chip on the multiplexed
// A_D/RD/WR/CS bus. Synchronizes every bus input, decodes address and data
// phases with a three-state FSM, holds a 16-byte register file and drives
// read data back onto the bus.
// Optional feature macro: RTC_RESP_TICK_EN. When defined, the 1 Hz tick
// advances BCD seconds/minutes/hours (registers 0x01-0x03) unless STOP is set.
module rtc_bus_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic       A_D,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic       tick,
    output logic [7:0] addr_q,
    output logic       wr_done,
    output logic       bus_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WR_ACT = 2'd1;
    localparam logic [1:0] ST_RD_ACT = 2'd2;

    // Packed bus word {CS, RD, WR, A_D, ad_in}; strobes idle high, rest low.
    localparam logic [11:0] SYNC_RST = 12'hE00;

    logic [SYNC_STAGES-1:0][11:0] sync_q, sync_d;
    logic [1:0]        state_q, state_d;
    logic [7:0]        addr_d;
    logic              wr_done_q, wr_done_d;
    logic              bus_err_q, bus_err_d;
    logic [15:0][7:0]  regs_q, regs_d;

    logic              cs_s, rd_s, wr_s, ad_s;
    logic [7:0]        din_s;
    logic              addr_in_range;

`ifdef RTC_RESP_TICK_EN
    // BCD increment with wrap to 0x00 once the value reaches max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v)
            r = 8'h00;
        else if (v[3:0] >= 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction
`else
    logic unused_tick;
    assign unused_tick = tick;
`endif

    assign cs_s  = sync_q[SYNC_STAGES-1][11];
    assign rd_s  = sync_q[SYNC_STAGES-1][10];
    assign wr_s  = sync_q[SYNC_STAGES-1][9];
    assign ad_s  = sync_q[SYNC_STAGES-1][8];
    assign din_s = sync_q[SYNC_STAGES-1][7:0];

    assign addr_in_range = (addr_q < 8'h10);

    // Shift the raw bus pins through the synchronizer chain.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {CS, RD, WR, A_D, ad_in};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Bus FSM, write commit, error flag and optional clock advance.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_done_d = 1'b0;
        bus_err_d = bus_err_q | (~cs_s & ~rd_s & ~wr_s);
        regs_d    = regs_q;

`ifdef RTC_RESP_TICK_EN
        // Tick first, so a same-cycle bus write below overrides only its target.
        if (tick && !regs_q[0][0]) begin
            regs_d[1] = bcd_inc(regs_q[1], 8'h59);
            if (regs_q[1] == 8'h59) begin
                regs_d[2] = bcd_inc(regs_q[2], 8'h59);
                if (regs_q[2] == 8'h59) begin
                    regs_d[3] = bcd_inc(regs_q[3], 8'h23);
                end
            end
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (!cs_s && !wr_s && rd_s)
                    state_d = ST_WR_ACT;
                else if (!cs_s && !rd_s && wr_s)
                    state_d = ST_RD_ACT;
            end
            ST_WR_ACT: begin
                // Commit on exit, even when CS rose before WR.
                if (wr_s || cs_s) begin
                    state_d = ST_IDLE;
                    if (!ad_s) begin
                        addr_d = din_s;
                    end else begin
                        wr_done_d = 1'b1;
                        if (addr_in_range)
                            regs_d[addr_q[3:0]] = din_s;
                    end
                end
            end
            ST_RD_ACT: begin
                if (rd_s || cs_s)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Drive data only during a data-phase read; out-of-range reads return 0.
    always_comb begin
        ad_oe  = (state_q == ST_RD_ACT) && ad_s;
        ad_out = (ad_oe && addr_in_range) ? regs_q[addr_q[3:0]] : 8'h00;
    end

    assign wr_done = wr_done_q;
    assign bus_err = bus_err_q;

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= {SYNC_STAGES{SYNC_RST}};
            state_q   <= ST_IDLE;
            addr_q    <= 8'h00;
            wr_done_q <= 1'b0;
            bus_err_q <= 1'b0;
            regs_q    <= '0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_done_q <= wr_done_d;
            bus_err_q <= bus_err_d;
            regs_q    <= regs_d;
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: drives initiator bus cycles, keeps a small
// register-file model, and queues expected read data at drive time for
// comparison when the responder enables its output.
module tb_rtc_bus_responder;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       CS, RD, WR, A_D, tick;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] addr_q;
    logic       wr_done;
    logic       bus_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mdl [16];
    logic [7:0] mdl_addr;
    logic [7:0] exp_q [$];

    rtc_bus_responder #(.SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .reset   (reset),
        .CS      (CS),
        .RD      (RD),
        .WR      (WR),
        .A_D     (A_D),
        .ad_in   (ad_in),
        .ad_out  (ad_out),
        .ad_oe   (ad_oe),
        .tick    (tick),
        .addr_q  (addr_q),
        .wr_done (wr_done),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic bus_write(input logic ad, input logic [7:0] d, input logic tk);
        int lat;
        int pulses;
        lat    = -1;
        pulses = 0;
        @(posedge clk); #1;
        CS = 1'b0; A_D = ad; ad_in = d; WR = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1 WR = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) CS = 1'b1;
            tick = tk && (i == SYNC);
            @(negedge clk);
            if (wr_done) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        if (!ad) begin
            mdl_addr = d;
            chk("addr_wr_done_cnt", pulses, 0);
            chk("addr_q", addr_q, d);
        end else begin
            if (mdl_addr < 8'h10) mdl[mdl_addr[3:0]] = d;
            chk("wr_done_cnt", pulses, 1);
            chk("wr_done_lat", lat, SYNC + 1);
        end
    endtask

    task automatic bus_read(input string tag);
        int lat;
        logic [7:0] e;
        lat = -1;
        exp_q.push_back((mdl_addr < 8'h10) ? mdl[mdl_addr[3:0]] : 8'h00);
        @(posedge clk); #1;
        CS = 1'b0; A_D = 1'b1; RD = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ad_oe) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, SYNC + 1);
        e = exp_q.pop_front();
        if (lat > 0) chk(tag, ad_out, e);
        repeat (2) @(posedge clk);
        #1 RD = 1'b1;
        @(posedge clk); #1 CS = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_oe_off"}, ad_oe, 0);
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int oe_cnt;
        int wd_cnt;
        CS = 1'b1; RD = 1'b1; WR = 1'b1; A_D = 1'b0; ad_in = 8'h00; tick = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mdl_addr = 8'h00;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_ad_oe",   ad_oe,   0);
        chk("rst_ad_out",  ad_out,  0);
        chk("rst_addr_q",  addr_q,  0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_bus_err", bus_err, 0);

        // Basic address/data write then read back.
        bus_write(1'b0, 8'h05, 1'b0);
        bus_write(1'b1, 8'hA7, 1'b0);
        bus_read("rd_a7");

        // Out-of-range address: write ignored, read returns zero.
        bus_write(1'b0, 8'h20, 1'b0);
        bus_write(1'b1, 8'h55, 1'b0);
        bus_read("rd_oob");
        bus_write(1'b0, 8'h00, 1'b0);
        bus_read("rd_r0");
        bus_write(1'b0, 8'h05, 1'b0);
        bus_read("rd_r5_kept");

        // Both strobes low with CS low.
        oe_cnt = 0;
        wd_cnt = 0;
        @(posedge clk); #1;
        CS = 1'b0; RD = 1'b0; WR = 1'b0; A_D = 1'b1; ad_in = 8'hEE;
        for (int i = 0; i < SYNC + 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ad_oe) oe_cnt++;
            if (wr_done) wd_cnt++;
        end
        #1 CS = 1'b1; RD = 1'b1; WR = 1'b1;
        for (int i = 0; i < SYNC + 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ad_oe) oe_cnt++;
            if (wr_done) wd_cnt++;
        end
        chk("err_oe_cnt", oe_cnt, 0);
        chk("err_wd_cnt", wd_cnt, 0);
        chk("err_flag", bus_err, 1);
        chk("err_addr_q", addr_q, 8'h05);
        bus_read("rd_after_err");
        chk("err_sticky", bus_err, 1);

`ifdef RTC_RESP_TICK_EN
        // Full rollover 23:59:59 -> 00:00:00.
        bus_write(1'b0, 8'h01, 1'b0); bus_write(1'b1, 8'h59, 1'b0);
        bus_write(1'b0, 8'h02, 1'b0); bus_write(1'b1, 8'h59, 1'b0);
        bus_write(1'b0, 8'h03, 1'b0); bus_write(1'b1, 8'h23, 1'b0);
        pulse_tick();
        mdl[1] = 8'h00; mdl[2] = 8'h00; mdl[3] = 8'h00;
        bus_write(1'b0, 8'h01, 1'b0); bus_read("roll_sec");
        bus_write(1'b0, 8'h02, 1'b0); bus_read("roll_min");
        bus_write(1'b0, 8'h03, 1'b0); bus_read("roll_hr");

        // STOP=1 freezes the clock.
        bus_write(1'b0, 8'h01, 1'b0); bus_write(1'b1, 8'h59, 1'b0);
        bus_write(1'b0, 8'h02, 1'b0); bus_write(1'b1, 8'h59, 1'b0);
        bus_write(1'b0, 8'h03, 1'b0); bus_write(1'b1, 8'h23, 1'b0);
        bus_write(1'b0, 8'h00, 1'b0); bus_write(1'b1, 8'h01, 1'b0);
        pulse_tick();
        bus_write(1'b0, 8'h01, 1'b0); bus_read("stop_sec");
        bus_write(1'b0, 8'h02, 1'b0); bus_read("stop_min");
        bus_write(1'b0, 8'h03, 1'b0); bus_read("stop_hr");
        bus_write(1'b0, 8'h00, 1'b0); bus_write(1'b1, 8'h00, 1'b0);

        // Bus write coincident with tick wins for seconds.
        bus_write(1'b0, 8'h01, 1'b0); bus_write(1'b1, 8'h09, 1'b0);
        bus_write(1'b1, 8'h30, 1'b1);
        bus_read("tick_collide_sec");
        pulse_tick();
        mdl[1] = 8'h31;
        bus_read("tick_inc_sec");
        bus_write(1'b0, 8'h02, 1'b0); bus_read("tick_min_kept");
`else
        // Without the clock feature, tick leaves the registers alone.
        bus_write(1'b0, 8'h01, 1'b0); bus_write(1'b1, 8'h59, 1'b0);
        pulse_tick();
        bus_read("tick_ignored");
`endif

        // Asynchronous reset in the middle of a read.
        bus_write(1'b0, 8'h05, 1'b0);
        @(posedge clk); #1;
        CS = 1'b0; A_D = 1'b1; RD = 1'b0;
        oe_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ad_oe) begin
                oe_cnt = i;
                break;
            end
        end
        chk("mid_rst_oe_before", ad_oe, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_oe",      ad_oe,   0);
        chk("mid_rst_addr_q",  addr_q,  0);
        chk("mid_rst_ad_out",  ad_out,  0);
        chk("mid_rst_bus_err", bus_err, 0);
        CS = 1'b1; RD = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mdl_addr = 8'h00;
        bus_write(1'b0, 8'h05, 1'b0);
        bus_read("post_rst_r5");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
